ram_unloader: RTL and testbench

RAM_UNLOADER -- requirements
Module: ram_unloader

---
 rtl/ram_unloader.sv | 114 +++++++++++
 tb/tb_ram_unloader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_unloader.sv
// Captures a wide operand and streams it out one 32-bit word per accepted handshake.
// Optional RAM_UNLOADER_MSW_FIRST_EN: stream from the top word down to word 0.
module ram_unloader #(
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int BRAM_WORD_COUNT = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [32*BRAM_WORD_COUNT-1:0] dinb,
  input  logic                         web,
  output logic                         dinb_read,
  output logic [BRAM_ADDR_WIDTH-1:0]   addra,
  output logic [31:0]                  douta,
  output logic                         douta_valid,
  input  logic                         douta_ready,
  output logic                         douta_last,
  output logic                         busy
);

  localparam int unsigned IDXW = (BRAM_WORD_COUNT > 1) ? $clog2(BRAM_WORD_COUNT) : 1;

`ifdef RAM_UNLOADER_MSW_FIRST_EN
  localparam logic [IDXW-1:0] IDX_FIRST = IDXW'(BRAM_WORD_COUNT - 1);
  localparam logic [IDXW-1:0] IDX_FINAL = '0;
`else
  localparam logic [IDXW-1:0] IDX_FIRST = '0;
  localparam logic [IDXW-1:0] IDX_FINAL = IDXW'(BRAM_WORD_COUNT - 1);
`endif

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [31:0]       buf_q [BRAM_WORD_COUNT];
  logic              read_q;
  logic              capture;
  logic              at_final;
  logic [IDXW+1:0]   byte_addr;

  assign at_final = (idx_q == IDX_FINAL);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (web) begin
          capture = 1'b1;
          idx_d   = IDX_FIRST;
          state_d = STREAM;
        end
      end
      STREAM: begin
        // web is deliberately not looked at here, including on the final transfer
        if (douta_ready) begin
          if (at_final) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
`ifdef RAM_UNLOADER_MSW_FIRST_EN
            idx_d = idx_q - IDXW'(1);
`else
            idx_d = idx_q + IDXW'(1);
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      read_q  <= capture;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < BRAM_WORD_COUNT; k++) buf_q[k] <= '0;
    end else if (capture) begin
      for (int unsigned k = 0; k < BRAM_WORD_COUNT; k++) buf_q[k] <= dinb[32*k +: 32];
    end
  end

  assign byte_addr = {idx_q, 2'b00};

  always_comb begin
    douta_valid = (state_q == STREAM);
    busy        = (state_q == STREAM);
    douta_last  = (state_q == STREAM) && at_final;
    dinb_read   = read_q;
    douta       = '0;
    addra       = '0;
    if (state_q == STREAM) begin
      douta = buf_q[idx_q];
      addra = BRAM_ADDR_WIDTH'(byte_addr);
    end
  end

endmodule

// File: tb/tb_ram_unloader.sv
// Randomized self-checking bench for ram_unloader (32 words, 10-bit address).
module tb_ram_unloader;

  localparam int AW = 10;
  localparam int WC = 32;
  localparam int W  = 32 * WC;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [W-1:0]  dinb = '0;
  logic          web = 1'b0;
  logic          dinb_read;
  logic [AW-1:0] addra;
  logic [31:0]   douta;
  logic          douta_valid;
  logic          douta_ready = 1'b0;
  logic          douta_last;
  logic          busy;

  int checks = 0;
  int errors = 0;

  ram_unloader #(.BRAM_ADDR_WIDTH(AW), .BRAM_WORD_COUNT(WC)) dut (
    .clk(clk), .resetn(resetn), .dinb(dinb), .web(web), .dinb_read(dinb_read),
    .addra(addra), .douta(douta), .douta_valid(douta_valid), .douta_ready(douta_ready),
    .douta_last(douta_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: the n-th word to appear in the stream and its byte address.
  function automatic int word_index(input int n);
`ifdef RAM_UNLOADER_MSW_FIRST_EN
    return WC - 1 - n;
`else
    return n;
`endif
  endfunction

  function automatic logic [31:0] exp_word(input logic [W-1:0] d, input int n);
    return d[32*word_index(n) +: 32];
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int n);
    int a;
    a = (word_index(n) * 4) % (1 << AW);
    return a[AW-1:0];
  endfunction

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] d;
    for (int k = 0; k < WC; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({dinb_read, douta_valid, douta_last, busy, addra, douta} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {dinb_read, douta_valid, douta_last, busy, addra, douta});
    end
  endtask

  task automatic test_in_order();
    logic [W-1:0] d;
    for (int k = 0; k < WC; k++) d[32*k +: 32] = 32'hA500_0000 + k;
    resetn = 1'b1; dinb = d; web = 1'b1; douta_ready = 1'b1;
    @(negedge clk);
    web = 1'b0;
    for (int n = 0; n < WC; n++) begin
      checks++;
      if ({dinb_read, busy, douta_valid, douta_last, addra, douta} !==
          {n == 0, 1'b1, 1'b1, n == WC - 1, exp_addr(n), exp_word(d, n)}) begin
        errors++;
        $display("FAIL in_order n=%0d got rd=%b busy=%b v=%b last=%b a=%h d=%h want a=%h d=%h",
                 n, dinb_read, busy, douta_valid, douta_last, addra, douta, exp_addr(n), exp_word(d, n));
      end
      @(negedge clk);
    end
    checks++;
    if ({dinb_read, douta_valid, douta_last, busy, addra, douta} !== '0) begin
      errors++;
      $display("FAIL in_order_idle got %h want 0", {dinb_read, douta_valid, douta_last, busy, addra, douta});
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d;
    int n, cyc;
    d = rand_data();
    dinb = d; web = 1'b1; douta_ready = 1'b1;
    @(negedge clk);
    web = 1'b0;
    n = 0; cyc = 0;
    while (n < WC && cyc < 1000) begin
      checks++;
      if ({douta_valid, busy, douta_last, addra, douta} !==
          {1'b1, 1'b1, n == WC - 1, exp_addr(n), exp_word(d, n)}) begin
        errors++;
        $display("FAIL backpressure n=%0d got v=%b last=%b a=%h d=%h want a=%h d=%h",
                 n, douta_valid, douta_last, addra, douta, exp_addr(n), exp_word(d, n));
      end
      if (douta_ready) n++;
      @(negedge clk);
      cyc++;
      douta_ready = (cyc % 3 == 0);
    end
    checks++;
    if (n != WC || douta_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_end transfers=%0d v=%b busy=%b want %0d 0 0", n, douta_valid, busy, WC);
    end
  endtask

  task automatic test_web_in_stream();
    logic [W-1:0] d;
    int n, cyc;
    d = rand_data();
    dinb = d; web = 1'b1; douta_ready = 1'b1;
    @(negedge clk);
    web = 1'b0;
    n = 0; cyc = 0;
    while (n < WC && cyc < 1000) begin
      checks++;
      if ({dinb_read, douta_valid, douta_last, addra, douta} !==
          {n == 0 && cyc == 0, 1'b1, n == WC - 1, exp_addr(n), exp_word(d, n)}) begin
        errors++;
        $display("FAIL web_in_stream n=%0d got rd=%b v=%b last=%b a=%h d=%h want a=%h d=%h",
                 n, dinb_read, douta_valid, douta_last, addra, douta, exp_addr(n), exp_word(d, n));
      end
      // Hit the final-word transfer with web too, so that case is ignored as well.
      web = (n == 5) || (n == WC - 1 && douta_ready);
      if (web) dinb = rand_data();
      if (douta_ready) n++;
      @(negedge clk);
      cyc++;
      douta_ready = $urandom_range(0, 1);
    end
    web = 1'b0;
    checks++;
    if (n != WC || {dinb_read, douta_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL web_in_stream_end transfers=%0d rd=%b v=%b busy=%b", n, dinb_read, douta_valid, busy);
    end
  endtask

  task automatic test_idle_ready();
    douta_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({dinb_read, douta_valid, douta_last, busy, addra, douta} !== '0) begin
        errors++;
        $display("FAIL idle_ready got %h want 0", {dinb_read, douta_valid, douta_last, busy, addra, douta});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d;
    d = rand_data();
    dinb = d; web = 1'b1; douta_ready = 1'b1;
    @(negedge clk);
    web = 1'b0;
    for (int n = 0; n < 10; n++) begin
      checks++;
      if ({douta_valid, addra, douta} !== {1'b1, exp_addr(n), exp_word(d, n)}) begin
        errors++;
        $display("FAIL reset_mid_pre n=%0d got a=%h d=%h want a=%h d=%h", n, addra, douta, exp_addr(n), exp_word(d, n));
      end
      @(negedge clk);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({dinb_read, douta_valid, douta_last, busy, addra, douta} !== '0) begin
      errors++;
      $display("FAIL reset_async got %h want 0", {dinb_read, douta_valid, douta_last, busy, addra, douta});
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({dinb_read, douta_valid, busy, addra, douta} !== '0) begin
        errors++;
        $display("FAIL reset_mid_after got %h want 0", {dinb_read, douta_valid, busy, addra, douta});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] da, db;
    da = rand_data();
    db = rand_data();
    dinb = da; web = 1'b1; douta_ready = 1'b1;
    @(negedge clk);
    dinb = db;
    for (int n = 0; n < WC; n++) begin
      checks++;
      if ({dinb_read, douta_valid, douta_last, addra, douta} !==
          {n == 0, 1'b1, n == WC - 1, exp_addr(n), exp_word(da, n)}) begin
        errors++;
        $display("FAIL b2b_first n=%0d got rd=%b v=%b a=%h d=%h want a=%h d=%h",
                 n, dinb_read, douta_valid, addra, douta, exp_addr(n), exp_word(da, n));
      end
      @(negedge clk);
    end
    checks++;
    if ({dinb_read, douta_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_gap got rd=%b v=%b busy=%b want 000", dinb_read, douta_valid, busy);
    end
    @(negedge clk);
    web = 1'b0;
    for (int n = 0; n < WC; n++) begin
      checks++;
      if ({dinb_read, douta_valid, douta_last, addra, douta} !==
          {n == 0, 1'b1, n == WC - 1, exp_addr(n), exp_word(db, n)}) begin
        errors++;
        $display("FAIL b2b_second n=%0d got rd=%b v=%b a=%h d=%h want a=%h d=%h",
                 n, dinb_read, douta_valid, addra, douta, exp_addr(n), exp_word(db, n));
      end
      @(negedge clk);
    end
    checks++;
    if ({dinb_read, douta_valid, busy, douta_last} !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_end got rd=%b v=%b busy=%b last=%b want 0000", dinb_read, douta_valid, busy, douta_last);
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_idle_ready();
    test_backpressure();
    test_web_in_stream();
    test_idle_ready();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
